z80_bus_fabric: RTL and testbench

Z80_BUS_FABRIC -- requirements
Module: z80_bus_fabric

---
 rtl/z80_bus_fabric_if.sv | 37 +++
 rtl/z80_bus_fabric.sv | 221 ++++++++++++++++++++++
 tb/tb_z80_bus_fabric.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/z80_bus_fabric_if.sv
// Z80 bus fabric signal bundle. Both modports describe the fabric's view:
// "master" faces the bus masters, "slave" faces the decoded slaves.
interface z80_bus_fabric_if #(
  parameter int MASTERS = 2,
  parameter int SLAVES  = 4
);
  logic                  cpu_ce;
  logic [MASTERS-1:0]    m_busrq_n;
  logic [MASTERS-1:0]    m_busak_n;
  logic [MASTERS-1:0]    m_mreq_n;
  logic [MASTERS-1:0]    m_iorq_n;
  logic [MASTERS-1:0]    m_rd_n;
  logic [MASTERS-1:0]    m_wr_n;
  logic [MASTERS*16-1:0] m_addr;
  logic [MASTERS*8-1:0]  m_dout;
  logic [7:0]            m_din;
  logic                  m_wait_n;
  logic                  decode_err;

  logic [SLAVES-1:0]     s_sel;
  logic [15:0]           s_addr;
  logic [7:0]            s_wdata;
  logic                  s_rd_n;
  logic                  s_wr_n;
  logic [SLAVES*8-1:0]   s_rdata;
  logic [SLAVES*4-1:0]   s_wait_cfg;

  modport master (
    input  m_busrq_n, m_mreq_n, m_iorq_n, m_rd_n, m_wr_n, m_addr, m_dout,
    output cpu_ce, m_busak_n, m_din, m_wait_n, decode_err
  );

  modport slave (
    output s_sel, s_addr, s_wdata, s_rd_n, s_wr_n,
    input  s_rdata, s_wait_cfg
  );
endinterface

// File: rtl/z80_bus_fabric.sv
// Multi-master Z80 bus fabric: clock-enable divider, round-robin bus arbiter,
// address/space decoder with lowest-index priority and per-slave wait states.
module z80_bus_fabric #(
  parameter int                   MASTERS    = 2,
  parameter int                   SLAVES     = 4,
  parameter int                   CLK_DIV    = 2,
  parameter logic [SLAVES*16-1:0] SLAVE_BASE = {16'h0010, 16'h0000, 16'h8000, 16'h0000},
  parameter logic [SLAVES*16-1:0] SLAVE_MASK = {16'h00F0, 16'h00F0, 16'h8000, 16'h8000},
  parameter logic [SLAVES-1:0]    SLAVE_IO   = 4'b1100
) (
  input  logic                   masterclk,
  input  logic                   reset_n,
  z80_bus_fabric_if.master       mb,
  z80_bus_fabric_if.slave        sb
);

  localparam int OW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {OWN0, DRAIN, OWNX} arb_state_t;

  arb_state_t        r_state, w_state_nxt;
  logic [OW-1:0]     r_owner, w_owner_nxt;
  logic [OW-1:0]     r_winner, w_winner_nxt;
  logic [OW-1:0]     r_rr, w_rr_nxt;
  logic [OW-1:0]     w_pick, w_after_winner;
  logic              w_found;
  logic [MASTERS-1:0] w_req;
  logic [MASTERS-1:0] w_busak_n;
  int unsigned       k;

  logic [DW-1:0]     r_div;
  logic              r_ce;

  logic              w_mreq_n, w_iorq_n, w_rd_n, w_wr_n, w_busrq_n, w_idle;
  logic [15:0]       w_addr;
  logic [7:0]        w_dout;

  logic [SLAVES-1:0] w_sel;
  logic              w_hit;
  logic [7:0]        w_rdata;
  logic [3:0]        w_wcfg;
  logic              w_lead, w_space;

  logic              r_rd_q, r_wr_q;
  logic              r_wait_n;
  logic [3:0]        r_wait_cnt;
  logic              r_derr;

  always_ff @(posedge masterclk) begin
    if (!reset_n) begin
      r_div <= '0;
      r_ce  <= 1'b0;
    end else if (r_div == DW'(CLK_DIV - 1)) begin
      r_div <= '0;
      r_ce  <= 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
      r_ce  <= 1'b0;
    end
  end

  always_comb begin
    w_mreq_n  = 1'b1;
    w_iorq_n  = 1'b1;
    w_rd_n    = 1'b1;
    w_wr_n    = 1'b1;
    w_busrq_n = 1'b1;
    w_addr    = '0;
    w_dout    = '0;
    for (int unsigned j = 0; j < MASTERS; j++) begin
      if (OW'(j) == r_owner) begin
        w_mreq_n  = mb.m_mreq_n[j];
        w_iorq_n  = mb.m_iorq_n[j];
        w_rd_n    = mb.m_rd_n[j];
        w_wr_n    = mb.m_wr_n[j];
        w_busrq_n = mb.m_busrq_n[j];
        w_addr    = mb.m_addr[j*16 +: 16];
        w_dout    = mb.m_dout[j*8 +: 8];
      end
    end
    w_idle = w_mreq_n & w_iorq_n & w_rd_n & w_wr_n;
  end

  // Requests from masters 1..MASTERS-1; the current OWNX owner is excluded so
  // a pending competitor is detected while the owner keeps its request low.
  always_comb begin
    for (int unsigned j = 0; j < MASTERS; j++)
      w_req[j] = (j != 0) && !mb.m_busrq_n[j] &&
                 !((r_state == OWNX) && (OW'(j) == r_owner));
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    k       = 0;
    for (int unsigned i = 0; i < MASTERS - 1; i++) begin
      k = 32'(r_rr) + i;
      if (k >= MASTERS) k = k - (MASTERS - 1);
      if (!w_found && w_req[k[OW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = k[OW-1:0];
      end
    end
    w_after_winner = (r_winner == OW'(MASTERS - 1)) ? OW'(1) : r_winner + 1'b1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_winner_nxt = r_winner;
    w_rr_nxt     = r_rr;
    if (r_ce && r_wait_n) begin
      case (r_state)
        OWN0: begin
          if (w_found) begin
            w_state_nxt  = DRAIN;
            w_winner_nxt = w_pick;
          end
        end
        DRAIN: begin
          if (w_idle) begin
            w_state_nxt = OWNX;
            w_owner_nxt = r_winner;
            w_rr_nxt    = w_after_winner;
          end
        end
        OWNX: begin
          if (w_idle) begin
            if (w_found) begin
              w_state_nxt  = DRAIN;
              w_winner_nxt = w_pick;
            end else if (w_busrq_n) begin
              w_state_nxt = OWN0;
              w_owner_nxt = '0;
            end
          end
        end
        default: begin
          w_state_nxt = OWN0;
          w_owner_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge masterclk) begin
    if (!reset_n) begin
      r_state  <= OWN0;
      r_owner  <= '0;
      r_winner <= OW'(1);
      r_rr     <= OW'(1);
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_winner <= w_winner_nxt;
      r_rr     <= w_rr_nxt;
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < MASTERS; j++)
      w_busak_n[j] = (r_state == OWNX) ? (OW'(j) != r_owner) : (j != 0);
  end

  always_comb begin
    w_sel   = '0;
    w_hit   = 1'b0;
    w_rdata = 8'hFF;
    w_wcfg  = '0;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      if (!w_hit && ((w_addr & SLAVE_MASK[i*16 +: 16]) == SLAVE_BASE[i*16 +: 16]) &&
          (SLAVE_IO[i] ? !w_iorq_n : !w_mreq_n)) begin
        w_hit    = 1'b1;
        w_sel[i] = 1'b1;
        w_rdata  = sb.s_rdata[i*8 +: 8];
        w_wcfg   = sb.s_wait_cfg[i*4 +: 4];
      end
    end
    w_lead  = (r_rd_q & ~w_rd_n) | (r_wr_q & ~w_wr_n);
    w_space = ~w_mreq_n | ~w_iorq_n;
  end

  // Strobe abort takes priority; wait releases the cycle after the count hits 0.
  always_ff @(posedge masterclk) begin
    if (!reset_n) begin
      r_rd_q     <= 1'b1;
      r_wr_q     <= 1'b1;
      r_wait_n   <= 1'b1;
      r_wait_cnt <= '0;
      r_derr     <= 1'b0;
    end else begin
      r_rd_q <= w_rd_n;
      r_wr_q <= w_wr_n;
      r_derr <= w_lead & w_space & ~w_hit;
      if (!r_wait_n && w_rd_n && w_wr_n) begin
        r_wait_cnt <= '0;
        r_wait_n   <= 1'b1;
      end else if (w_lead && w_hit && (w_wcfg != 4'd0)) begin
        r_wait_cnt <= w_wcfg;
        r_wait_n   <= 1'b0;
      end else if (!r_wait_n) begin
        if (r_wait_cnt == 4'd0) r_wait_n <= 1'b1;
        else if (r_ce)          r_wait_cnt <= r_wait_cnt - 1'b1;
      end
    end
  end

  assign mb.cpu_ce     = r_ce;
  assign mb.m_busak_n  = w_busak_n;
  assign mb.m_din      = w_rdata;
  assign mb.m_wait_n   = r_wait_n;
  assign mb.decode_err = r_derr;

  assign sb.s_sel   = w_sel;
  assign sb.s_addr  = w_addr;
  assign sb.s_wdata = w_dout;
  assign sb.s_rd_n  = w_rd_n;
  assign sb.s_wr_n  = w_wr_n;

endmodule

// File: tb/tb_z80_bus_fabric.sv
// Directed bench for z80_bus_fabric: a 2-master default instance plus a
// 3-master instance with overlapping decode windows.
module tb_z80_bus_fabric;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  z80_bus_fabric_if #(.MASTERS(2), .SLAVES(4)) bus2 ();
  z80_bus_fabric_if #(.MASTERS(3), .SLAVES(4)) bus3 ();

  z80_bus_fabric #(.MASTERS(2), .SLAVES(4), .CLK_DIV(2)) u_dut (
    .masterclk(clk), .reset_n(rst_n), .mb(bus2), .sb(bus2)
  );

  z80_bus_fabric #(
    .MASTERS(3), .SLAVES(4), .CLK_DIV(2),
    .SLAVE_BASE(64'h0010_0000_0000_0000),
    .SLAVE_MASK(64'h00F0_00F0_8000_C000),
    .SLAVE_IO(4'b1100)
  ) u_dut3 (
    .masterclk(clk), .reset_n(rst_n), .mb(bus3), .sb(bus3)
  );

  task automatic set_idle();
    bus2.m_busrq_n = '1; bus2.m_mreq_n = '1; bus2.m_iorq_n = '1;
    bus2.m_rd_n = '1;    bus2.m_wr_n = '1;   bus2.m_addr = '0; bus2.m_dout = '0;
    bus3.m_busrq_n = '1; bus3.m_mreq_n = '1; bus3.m_iorq_n = '1;
    bus3.m_rd_n = '1;    bus3.m_wr_n = '1;   bus3.m_addr = '0; bus3.m_dout = '0;
  endtask

  // Leaves the bench 1 time unit into the cycle right after a cpu_ce cycle.
  task automatic align_ce();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus2.cpu_ce) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus2.m_busak_n !== 2'b10) begin failures++; $display("FAIL rst_busak got=%b exp=10", bus2.m_busak_n); end
    checks++; if (bus2.m_wait_n !== 1'b1) begin failures++; $display("FAIL rst_wait got=%b exp=1", bus2.m_wait_n); end
    checks++; if (bus2.cpu_ce !== 1'b0) begin failures++; $display("FAIL rst_ce got=%b exp=0", bus2.cpu_ce); end
    checks++; if (bus2.decode_err !== 1'b0) begin failures++; $display("FAIL rst_derr got=%b exp=0", bus2.decode_err); end
    checks++; if (bus2.s_sel !== 4'b0000 || bus2.m_din !== 8'hFF) begin failures++; $display("FAIL rst_idle sel=%b din=%h exp sel=0000 din=ff", bus2.s_sel, bus2.m_din); end
    checks++; if (bus3.m_busak_n !== 3'b110) begin failures++; $display("FAIL rst_busak3 got=%b exp=110", bus3.m_busak_n); end
    rst_n = 1'b1;
    cyc();
    checks++; if (bus2.cpu_ce !== 1'b0) begin failures++; $display("FAIL ce_edge1 got=%b exp=0", bus2.cpu_ce); end
    cyc();
    checks++; if (bus2.cpu_ce !== 1'b1) begin failures++; $display("FAIL ce_edge2 got=%b exp=1", bus2.cpu_ce); end
    cyc();
    checks++; if (bus2.cpu_ce !== 1'b0) begin failures++; $display("FAIL ce_edge3 got=%b exp=0", bus2.cpu_ce); end
    cyc();
    checks++; if (bus2.cpu_ce !== 1'b1) begin failures++; $display("FAIL ce_edge4 got=%b exp=1", bus2.cpu_ce); end
  endtask

  task automatic test_read_nowait();
    int low = 0;
    set_idle(); align_ce();
    bus2.m_addr[15:0] = 16'h0000; bus2.m_mreq_n[0] = 1'b0; bus2.m_rd_n[0] = 1'b0;
    #1;
    checks++; if (bus2.s_sel !== 4'b0001) begin failures++; $display("FAIL rd0_sel got=%b exp=0001", bus2.s_sel); end
    checks++; if (bus2.m_din !== 8'hA0) begin failures++; $display("FAIL rd0_din got=%h exp=a0", bus2.m_din); end
    checks++; if (bus2.s_rd_n !== 1'b0 || bus2.s_addr !== 16'h0000) begin failures++; $display("FAIL rd0_fwd rd_n=%b addr=%h exp 0/0000", bus2.s_rd_n, bus2.s_addr); end
    for (int i = 0; i < 8; i++) begin cyc(); if (bus2.m_wait_n !== 1'b1) low++; end
    checks++; if (low != 0) begin failures++; $display("FAIL rd0_nowait low_cycles=%0d exp=0", low); end
    set_idle(); #1;
    checks++; if (bus2.s_sel !== 4'b0000 || bus2.m_din !== 8'hFF) begin failures++; $display("FAIL rd0_release sel=%b din=%h exp 0000/ff", bus2.s_sel, bus2.m_din); end
  endtask

  task automatic test_wait();
    int low = 0;
    set_idle(); align_ce();
    bus2.m_addr[15:0] = 16'h8123; bus2.m_mreq_n[0] = 1'b0; bus2.m_rd_n[0] = 1'b0;
    #1;
    checks++; if (bus2.s_sel !== 4'b0010 || bus2.m_din !== 8'hB1) begin failures++; $display("FAIL rd1_sel sel=%b din=%h exp 0010/b1", bus2.s_sel, bus2.m_din); end
    cyc();
    checks++; if (bus2.m_wait_n !== 1'b0) begin failures++; $display("FAIL wait_start got=%b exp=0", bus2.m_wait_n); end
    low = 1;
    for (int i = 0; i < 11; i++) begin cyc(); if (bus2.m_wait_n === 1'b0) low++; end
    checks++; if (low != 6) begin failures++; $display("FAIL wait_len low_cycles=%0d exp=6", low); end
    checks++; if (bus2.m_wait_n !== 1'b1) begin failures++; $display("FAIL wait_end got=%b exp=1", bus2.m_wait_n); end
    set_idle(); cyc();
  endtask

  task automatic test_wait_abort();
    int low = 0;
    set_idle(); align_ce();
    bus2.m_addr[15:0] = 16'h8000; bus2.m_mreq_n[0] = 1'b0; bus2.m_rd_n[0] = 1'b0;
    cyc(); cyc();
    checks++; if (bus2.m_wait_n !== 1'b0) begin failures++; $display("FAIL abort_pre got=%b exp=0", bus2.m_wait_n); end
    set_idle();
    cyc();
    checks++; if (bus2.m_wait_n !== 1'b1) begin failures++; $display("FAIL abort_release got=%b exp=1", bus2.m_wait_n); end
    for (int i = 0; i < 8; i++) begin cyc(); if (bus2.m_wait_n !== 1'b1) low++; end
    checks++; if (low != 0) begin failures++; $display("FAIL abort_stays low_cycles=%0d exp=0", low); end
  endtask

  task automatic test_decode();
    set_idle(); align_ce();
    bus2.m_addr[15:0] = 16'h0080; bus2.m_dout[7:0] = 8'h55;
    bus2.m_iorq_n[0] = 1'b0; bus2.m_wr_n[0] = 1'b0;
    #1;
    checks++; if (bus2.s_sel !== 4'b0000 || bus2.s_wdata !== 8'h55) begin failures++; $display("FAIL miss_wr sel=%b wdata=%h exp 0000/55", bus2.s_sel, bus2.s_wdata); end
    cyc();
    checks++; if (bus2.decode_err !== 1'b1 || bus2.m_wait_n !== 1'b1) begin failures++; $display("FAIL miss_pulse derr=%b wait=%b exp 1/1", bus2.decode_err, bus2.m_wait_n); end
    cyc();
    checks++; if (bus2.decode_err !== 1'b0) begin failures++; $display("FAIL miss_width got=%b exp=0", bus2.decode_err); end
    set_idle(); align_ce();
    bus2.m_addr[15:0] = 16'h0080; bus2.m_iorq_n[0] = 1'b0; bus2.m_rd_n[0] = 1'b0;
    #1;
    checks++; if (bus2.m_din !== 8'hFF) begin failures++; $display("FAIL miss_rd got=%h exp=ff", bus2.m_din); end
    cyc();
    checks++; if (bus2.decode_err !== 1'b1) begin failures++; $display("FAIL miss_rd_pulse got=%b exp=1", bus2.decode_err); end
    set_idle(); align_ce();
    bus2.m_addr[15:0] = 16'h0013; bus2.m_iorq_n[0] = 1'b0; bus2.m_rd_n[0] = 1'b0;
    #1;
    checks++; if (bus2.s_sel !== 4'b1000 || bus2.m_din !== 8'hD3) begin failures++; $display("FAIL io_hit sel=%b din=%h exp 1000/d3", bus2.s_sel, bus2.m_din); end
    set_idle();
    bus3.m_addr[15:0] = 16'h1000; bus3.m_mreq_n[0] = 1'b0; bus3.m_rd_n[0] = 1'b0;
    #1;
    checks++; if (bus3.s_sel !== 4'b0001) begin failures++; $display("FAIL overlap_low got=%b exp=0001", bus3.s_sel); end
    bus3.m_addr[15:0] = 16'h5000;
    #1;
    checks++; if (bus3.s_sel !== 4'b0010) begin failures++; $display("FAIL overlap_hi got=%b exp=0010", bus3.s_sel); end
    set_idle(); cyc(); cyc();
  endtask

  task automatic test_handover();
    int bad = 0;
    set_idle(); align_ce();
    bus2.m_addr[15:0] = 16'h1234; bus2.m_mreq_n[0] = 1'b0; bus2.m_rd_n[0] = 1'b0;
    bus2.m_busrq_n[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin cyc(); if (bus2.m_busak_n !== 2'b10) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_busak early_grants=%0d exp=0", bad); end
    checks++; if (bus2.s_addr !== 16'h1234) begin failures++; $display("FAIL drain_route got=%h exp=1234", bus2.s_addr); end
    align_ce();
    bus2.m_mreq_n[0] = 1'b1; bus2.m_rd_n[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin cyc(); if (bus2.m_busak_n !== 2'b10) break; end
    checks++; if (bus2.m_busak_n !== 2'b01) begin failures++; $display("FAIL grant1 got=%b exp=01", bus2.m_busak_n); end
    bus2.m_addr[31:16] = 16'h0042; bus2.m_mreq_n[1] = 1'b0; bus2.m_rd_n[1] = 1'b0;
    #1;
    checks++; if (bus2.s_addr !== 16'h0042 || bus2.m_din !== 8'hA0) begin failures++; $display("FAIL m1_route addr=%h din=%h exp 0042/a0", bus2.s_addr, bus2.m_din); end
    align_ce();
    bus2.m_mreq_n[1] = 1'b1; bus2.m_rd_n[1] = 1'b1; bus2.m_busrq_n[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin cyc(); if (bus2.m_busak_n === 2'b10) break; end
    checks++; if (bus2.m_busak_n !== 2'b10) begin failures++; $display("FAIL return0 got=%b exp=10", bus2.m_busak_n); end
  endtask

  task automatic test_round_robin();
    int       ng = 0;
    int       own0 = 0;
    int       g[4];
    logic [2:0] prev;
    int       exp_g[4] = '{1, 2, 1, 2};
    set_idle();
    bus3.m_addr = {16'h2222, 16'h1111, 16'h0000};
    bus3.m_busrq_n = 3'b001;
    prev = bus3.m_busak_n;
    for (int i = 0; i < 200 && ng < 4; i++) begin
      cyc();
      if (bus3.m_busak_n != prev && (bus3.m_busak_n == 3'b101 || bus3.m_busak_n == 3'b011)) begin
        g[ng] = (bus3.m_busak_n == 3'b101) ? 1 : 2;
        ng++;
      end
      if (ng > 0 && bus3.s_addr == 16'h0000) own0++;
      prev = bus3.m_busak_n;
    end
    checks++; if (ng != 4) begin failures++; $display("FAIL rr_count grants=%0d exp=4", ng); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (i < ng && g[i] != exp_g[i]) begin failures++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, g[i], exp_g[i]); end
    end
    checks++; if (own0 != 0) begin failures++; $display("FAIL rr_no_own0 cpu_routed_cycles=%0d exp=0", own0); end
    bus3.m_busrq_n = '1;
    for (int i = 0; i < 20; i++) begin cyc(); if (bus3.m_busak_n === 3'b110) break; end
    checks++; if (bus3.m_busak_n !== 3'b110) begin failures++; $display("FAIL rr_return got=%b exp=110", bus3.m_busak_n); end
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    bus2.m_busrq_n[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin cyc(); if (bus2.m_busak_n === 2'b01) break; end
    checks++; if (bus2.m_busak_n !== 2'b01) begin failures++; $display("FAIL rmw_grant got=%b exp=01", bus2.m_busak_n); end
    align_ce();
    bus2.m_addr = {16'h8000, 16'h1234};
    bus2.m_mreq_n[1] = 1'b0; bus2.m_rd_n[1] = 1'b0;
    cyc(); cyc();
    checks++; if (bus2.m_wait_n !== 1'b0) begin failures++; $display("FAIL rmw_pre got=%b exp=0", bus2.m_wait_n); end
    rst_n = 1'b0;
    cyc();
    checks++; if (bus2.m_wait_n !== 1'b1 || bus2.m_busak_n !== 2'b10 || bus2.cpu_ce !== 1'b0) begin
      failures++; $display("FAIL rmw_reset wait=%b busak=%b ce=%b exp 1/10/0", bus2.m_wait_n, bus2.m_busak_n, bus2.cpu_ce);
    end
    checks++; if (bus2.s_addr !== 16'h1234) begin failures++; $display("FAIL rmw_route got=%h exp=1234", bus2.s_addr); end
    set_idle(); rst_n = 1'b1; cyc(); cyc();
  endtask

  initial begin
    bus2.s_rdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus2.s_wait_cfg = {4'd0, 4'd0, 4'd3, 4'd0};
    bus3.s_rdata = {8'h33, 8'h22, 8'h11, 8'h00};
    bus3.s_wait_cfg = '0;
    test_reset();
    test_read_nowait();
    test_wait();
    test_wait_abort();
    test_decode();
    test_handover();
    test_round_robin();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
